uart_poll_ctrl: RTL and testbench
=================================

Name: uart_poll_ctrl

Overview:
Polled UART controller that sequences serial TX and RX framing from the 16x oversampling baud tick produced by the clock generator (50 MHz / 54 → 925925 Hz → 57870 baud). It sits between the Z80 bus interface and the rxd/txd pins. The CPU sees a one-byte data register and a status register that it polls; the block raises no interrupts. Frame format is fixed at 8N1, LSB first.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit; must be even and at least 8
SYNC_STAGES, 2, flip-flop stages on rxd before use

Ports:
clock_in  in  1  system clock (50 MHz); all logic on its rising edge
reset  in  1  synchronous, active-high reset
baud_tick  in  1  one-clock_in-cycle enable at OVERSAMPLE x baud
cs  in  1  register select
wr  in  1  write strobe, one clock_in cycle, qualified by cs
rd  in  1  read strobe, one clock_in cycle, qualified by cs
addr  in  1  0 = data, 1 = status
din  in  8  write data
dout  out  8  read data, combinational from addr
rxd  in  1  serial input, asynchronous
txd  out  1  serial output

Behaviour:
- Reset: txd=1; tx_hold empty; TX and RX FSMs IDLE; rx_ready=0, overrun=0, ferr=0; rx_data=0x00; synchronizer stages preset to 1.
- Status register (addr 1): bit0 rx_ready, bit1 tx_hold_empty, bit2 tx_idle, bit3 overrun, bit4 ferr; bits 7:5 read 0. dout(addr 0)=rx_data.
- cs&rd&addr==0: on the same edge, clears rx_ready, overrun and ferr. A status read has no side effects.
- cs&wr&addr==0: if tx_hold is empty, loads din and marks it full; if it is full, the write is dropped and the held byte is unchanged. Writes to addr 1 are ignored.
- Counters advance only on cycles where baud_tick=1; state is held on all other cycles.
- TX FSM, IDLE→START→DATA→STOP:
  - In IDLE, on a baud_tick with tx_hold full: move tx_hold into the shift register, mark tx_hold empty, drive txd=0, enter START.
  - Each bit lasts exactly OVERSAMPLE ticks. DATA shifts out 8 bits, LSB first. STOP drives txd=1.
  - On the last tick of STOP: if tx_hold is full, go directly to START on that tick with no idle gap (back-to-back frames); otherwise go to IDLE.
  - tx_idle = (state==IDLE).
- RX FSM, IDLE→START→DATA→STOP→(WAIT_HIGH):
  - Sample the synchronized rxd (rxs) only on ticks.
  - IDLE: rxs==0 on a tick enters START with count 0.
  - START: at count OVERSAMPLE/2-1 (mid start bit), if rxs==1 it is a false start and returns to IDLE; else enter DATA.
  - DATA: sample at each mid-bit, OVERSAMPLE ticks apart, 8 samples LSB first, then enter STOP.
  - STOP: at mid stop bit, write the shift register to rx_data and set rx_ready. If rx_ready was already 1, set overrun; the new byte overwrites.
    - If rxs==1: go to IDLE.
    - If rxs==0: set ferr, keep the byte, go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE on the first tick with rxs==1.
- Simultaneous data read and RX completion on the same edge: completion wins. rx_ready ends at 1, overrun is set per the pre-edge rx_ready, and the read returns the old rx_data.
- Simultaneous write and TX hold unload on the same edge: the unload takes the old byte and the write is dropped (hold was full). The write is accepted only when the pre-edge hold is empty.
- Reset asserted mid-frame: both FSMs abort immediately and txd returns to 1 on the next edge. A partially received byte is discarded.
- Counter width is clog2(OVERSAMPLE) bits, plus a 3-bit bit index; all counters wrap only under FSM control.

Test Plan:
- TX single byte: baud_tick every 54 clocks, write 0x55 → txd shows 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each level held 16 ticks (864 clocks); tx_idle=1 after stop; status bit1 goes 0 then 1 one cycle after the write.
- TX back-to-back with drop: write 0x01, then 0x02 once hold is empty, then 0x03 while hold is full → two contiguous frames 0x01, 0x02 with no idle tick between them; 0x03 never transmitted.
- RX normal: drive 0xA5 8N1 at 16 ticks/bit → rx_data=0xA5, rx_ready=1 at mid stop bit, ferr=0, overrun=0; a data read returns 0xA5 and clears rx_ready.
- RX overrun plus simultaneous read: send 0x11 then 0x22 without reading → rx_data=0x22, overrun=1; repeat with a read landing on the completion edge → rx_ready=1 and overrun set.
- RX errors: a 5-tick low glitch on rxd → FSM returns to IDLE with rx_ready=0; a frame with stop bit=0 (0x3C) → ferr=1, rx_data=0x3C, no new start accepted until rxd returns high.
- Reset mid-frame: assert reset during TX bit 4 and RX bit 3 → next edge gives txd=1, status=0x06, rx_ready=0; next byte 0x7E is then sent and received correctly.

Source files
------------

// File: rtl/uart_poll_ctrl.sv
// Polled 8N1 UART: one-byte TX holding register and RX data register behind a
// two-address CPU window, bit timing derived from an oversampling baud tick.
module uart_poll_ctrl #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rxd,
    output logic       txd
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rxState_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    txState_t               r_txState, w_txStateNext;
    logic [CW-1:0]          r_txCnt, w_txCntNext;
    logic [2:0]             r_txBit, w_txBitNext;
    logic [7:0]             r_txShift, w_txShiftNext;
    logic                   r_txd, w_txdNext;
    logic [7:0]             r_txHold;
    logic                   r_txHoldFull;
    logic                   w_txUnload;

    rxState_t               r_rxState, w_rxStateNext;
    logic [CW-1:0]          r_rxCnt, w_rxCntNext;
    logic [2:0]             r_rxBit, w_rxBitNext;
    logic [7:0]             r_rxShift, w_rxShiftNext;
    logic                   w_rxDone;
    logic                   w_rxFerr;
    logic [7:0]             r_rxData;
    logic                   r_rxReady;
    logic                   r_overrun;
    logic                   r_ferr;

    logic                   w_wrData;
    logic                   w_rdData;
    logic [7:0]             w_status;

    assign w_wrData = cs & wr & ~addr;
    assign w_rdData = cs & rd & ~addr;
    assign w_rxs    = r_sync[SYNC_STAGES-1];

    // Stages preset high so a reset never looks like a start bit.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_txState <= TX_IDLE;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_txShift <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_txState <= w_txStateNext;
            r_txCnt   <= w_txCntNext;
            r_txBit   <= w_txBitNext;
            r_txShift <= w_txShiftNext;
            r_txd     <= w_txdNext;
        end
    end

    always_comb begin
        w_txStateNext = r_txState;
        w_txCntNext   = r_txCnt;
        w_txBitNext   = r_txBit;
        w_txShiftNext = r_txShift;
        w_txdNext     = r_txd;
        w_txUnload    = 1'b0;
        if (baud_tick) begin
            case (r_txState)
                TX_IDLE: begin
                    if (r_txHoldFull) begin
                        w_txUnload    = 1'b1;
                        w_txShiftNext = r_txHold;
                        w_txdNext     = 1'b0;
                        w_txCntNext   = '0;
                        w_txStateNext = TX_START;
                    end
                end
                TX_START: begin
                    if (r_txCnt == CNT_LAST) begin
                        w_txCntNext   = '0;
                        w_txBitNext   = '0;
                        w_txdNext     = r_txShift[0];
                        w_txStateNext = TX_DATA;
                    end else begin
                        w_txCntNext = r_txCnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_txCnt == CNT_LAST) begin
                        w_txCntNext = '0;
                        if (r_txBit == 3'd7) begin
                            w_txdNext     = 1'b1;
                            w_txStateNext = TX_STOP;
                        end else begin
                            w_txShiftNext = {1'b0, r_txShift[7:1]};
                            w_txdNext     = r_txShift[1];
                            w_txBitNext   = r_txBit + 3'd1;
                        end
                    end else begin
                        w_txCntNext = r_txCnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_txCnt == CNT_LAST) begin
                        w_txCntNext = '0;
                        // A waiting byte starts on this same tick: no idle gap.
                        if (r_txHoldFull) begin
                            w_txUnload    = 1'b1;
                            w_txShiftNext = r_txHold;
                            w_txdNext     = 1'b0;
                            w_txStateNext = TX_START;
                        end else begin
                            w_txStateNext = TX_IDLE;
                        end
                    end else begin
                        w_txCntNext = r_txCnt + 1'b1;
                    end
                end
                default: w_txStateNext = TX_IDLE;
            endcase
        end
    end

    // An unload implies the hold was full, so a coincident write is dropped.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_txHold     <= '0;
            r_txHoldFull <= 1'b0;
        end else if (w_txUnload) begin
            r_txHoldFull <= 1'b0;
        end else if (w_wrData && !r_txHoldFull) begin
            r_txHold     <= din;
            r_txHoldFull <= 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_rxState <= RX_IDLE;
            r_rxCnt   <= '0;
            r_rxBit   <= '0;
            r_rxShift <= '0;
        end else begin
            r_rxState <= w_rxStateNext;
            r_rxCnt   <= w_rxCntNext;
            r_rxBit   <= w_rxBitNext;
            r_rxShift <= w_rxShiftNext;
        end
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxCntNext   = r_rxCnt;
        w_rxBitNext   = r_rxBit;
        w_rxShiftNext = r_rxShift;
        w_rxDone      = 1'b0;
        w_rxFerr      = 1'b0;
        if (baud_tick) begin
            case (r_rxState)
                RX_IDLE: begin
                    if (!w_rxs) begin
                        w_rxCntNext   = '0;
                        w_rxStateNext = RX_START;
                    end
                end
                RX_START: begin
                    if (r_rxCnt == CNT_MID) begin
                        w_rxCntNext = '0;
                        w_rxBitNext = '0;
                        w_rxStateNext = w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        w_rxCntNext = r_rxCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rxCnt == CNT_LAST) begin
                        w_rxCntNext   = '0;
                        w_rxShiftNext = {w_rxs, r_rxShift[7:1]};
                        if (r_rxBit == 3'd7) begin
                            w_rxStateNext = RX_STOP;
                        end else begin
                            w_rxBitNext = r_rxBit + 3'd1;
                        end
                    end else begin
                        w_rxCntNext = r_rxCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rxCnt == CNT_LAST) begin
                        w_rxCntNext = '0;
                        w_rxDone    = 1'b1;
                        if (w_rxs) begin
                            w_rxStateNext = RX_IDLE;
                        end else begin
                            w_rxFerr      = 1'b1;
                            w_rxStateNext = RX_WAIT_HIGH;
                        end
                    end else begin
                        w_rxCntNext = r_rxCnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rxs) begin
                        w_rxStateNext = RX_IDLE;
                    end
                end
                default: w_rxStateNext = RX_IDLE;
            endcase
        end
    end

    // Frame completion takes priority over a coincident data read.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_rxData  <= '0;
            r_rxReady <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (w_rxDone) begin
            r_rxData  <= r_rxShift;
            r_rxReady <= 1'b1;
            r_overrun <= r_rxReady | (r_overrun & ~w_rdData);
            r_ferr    <= w_rxFerr | (r_ferr & ~w_rdData);
        end else if (w_rdData) begin
            r_rxReady <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end
    end

    assign w_status = {3'b000, r_ferr, r_overrun, (r_txState == TX_IDLE), ~r_txHoldFull, r_rxReady};
    assign dout     = addr ? w_status : r_rxData;
    assign txd      = r_txd;

endmodule

// File: tb/tb_uart_poll_ctrl.sv
// Directed bench for uart_poll_ctrl: register-access vector table, then
// hand-timed TX/RX frame sequences checked tick by tick against bench constants.
module tb_uart_poll_ctrl;

    localparam int TICK_DIV = 8;

    logic       clock_in;
    logic       reset;
    logic       baud_tick;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rxd;
    logic       txd;

    logic       tickEnable;
    int         nChecks;
    int         nFail;

    typedef struct {
        logic       cs;
        logic       wr;
        logic       rd;
        logic       addr;
        logic [7:0] din;
        logic       chkAddr;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs[8];

    uart_poll_ctrl #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .baud_tick(baud_tick),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .rxd      (rxd),
        .txd      (txd)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // One-cycle tick every TICK_DIV clocks with a fixed phase; gated off while
    // the register table runs so the held byte stays put.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(posedge clock_in);
            #1 baud_tick = tickEnable;
            @(posedge clock_in);
            #1 baud_tick = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clock_in);
            while (!baud_tick) @(posedge clock_in);
        end
    endtask

    task automatic peekStatus(output logic [7:0] v);
        addr = 1'b1;
        #1 v = dout;
    endtask

    task automatic peekData(output logic [7:0] v);
        addr = 1'b0;
        #1 v = dout;
        addr = 1'b1;
    endtask

    task automatic cpuWrite(input logic a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; din = d;
        @(posedge clock_in);
        #1 cs = 1'b0; wr = 1'b0; addr = 1'b1;
    endtask

    task automatic cpuRead(output logic [7:0] v);
        cs = 1'b1; rd = 1'b1; addr = 1'b0;
        #1 v = dout;
        @(posedge clock_in);
        #1 cs = 1'b0; rd = 1'b0; addr = 1'b1;
    endtask

    task automatic applyStimulus(input int idx);
        logic [7:0] v;
        cs = vecs[idx].cs; wr = vecs[idx].wr; rd = vecs[idx].rd;
        addr = vecs[idx].addr; din = vecs[idx].din;
        @(posedge clock_in);
        #1 cs = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = vecs[idx].chkAddr;
        #1 v = dout;
        checkOutput($sformatf("table[%0d]", idx), v, vecs[idx].expDout);
        addr = 1'b1;
    endtask

    // Caller is just past the tick edge on which the start bit began; each
    // level is checked one tick after it starts and one tick before it ends.
    task automatic checkTxFrame(input logic [7:0] b, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            waitTicks(1);
            #1 checkOutput($sformatf("%s bit%0d early", tag, i), {7'b0, txd}, {7'b0, frame[i]});
            waitTicks(14);
            #1 checkOutput($sformatf("%s bit%0d late", tag, i), {7'b0, txd}, {7'b0, frame[i]});
            waitTicks(1);
            #1;
        end
    endtask

    task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
        waitTicks(1);
        #1 rxd = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            waitTicks(16);
        end
        #1 rxd = stopBit;
        waitTicks(16);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] oldData;

        nChecks = 0;
        nFail   = 0;
        reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 1'b1; din = 8'h00;
        rxd = 1'b1; tickEnable = 1'b0;

        //                cs    wr    rd    addr  din    chk   exp
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h06};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b1, 8'h06};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 8'h06};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h04};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 8'h04};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h04};

        repeat (3) @(posedge clock_in);
        #1 reset = 1'b0;
        checkOutput("reset txd", {7'b0, txd}, 8'h01);

        $display("[TB] register access table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i);
        end

        $display("[TB] held byte 0x5A goes out, dropped 0xC3 never does");
        tickEnable = 1'b1;
        waitTicks(1);
        #1;
        checkTxFrame(8'h5A, "tx5A");
        peekStatus(v);
        checkOutput("tx5A status after", v, 8'h06);
        waitTicks(20);
        #1 checkOutput("tx5A line idle", {7'b0, txd}, 8'h01);

        $display("[TB] TX single byte 0x55");
        waitTicks(1);
        #1 cpuWrite(1'b0, 8'h55);
        peekStatus(v);
        checkOutput("tx55 hold full", v, 8'h04);
        waitTicks(1);
        #1 peekStatus(v);
        checkOutput("tx55 hold unloaded", v, 8'h02);
        checkTxFrame(8'h55, "tx55");
        peekStatus(v);
        checkOutput("tx55 idle after", v, 8'h06);

        $display("[TB] TX back-to-back with dropped write");
        waitTicks(1);
        #1 cpuWrite(1'b0, 8'h01);
        waitTicks(1);
        #1 cpuWrite(1'b0, 8'h02);
        cpuWrite(1'b0, 8'h03);
        peekStatus(v);
        checkOutput("b2b hold full busy", v, 8'h00);
        checkTxFrame(8'h01, "b2b01");
        checkTxFrame(8'h02, "b2b02");
        peekStatus(v);
        checkOutput("b2b idle after", v, 8'h06);
        for (int i = 0; i < 4; i++) begin
            waitTicks(5);
            #1 checkOutput("b2b no third frame", {7'b0, txd}, 8'h01);
        end

        $display("[TB] RX normal 0xA5");
        sendRxFrame(8'hA5, 1'b1);
        peekStatus(v);
        checkOutput("rxA5 status", v, 8'h07);
        cpuRead(v);
        checkOutput("rxA5 data", v, 8'hA5);
        peekStatus(v);
        checkOutput("rxA5 cleared", v, 8'h06);

        $display("[TB] RX overrun");
        sendRxFrame(8'h11, 1'b1);
        sendRxFrame(8'h22, 1'b1);
        peekStatus(v);
        checkOutput("ovr status", v, 8'h0F);
        peekData(v);
        checkOutput("ovr data", v, 8'h22);
        cpuRead(v);
        checkOutput("ovr read", v, 8'h22);
        peekStatus(v);
        checkOutput("ovr cleared", v, 8'h06);

        $display("[TB] RX completion coincident with data read");
        sendRxFrame(8'h33, 1'b1);
        peekStatus(v);
        checkOutput("rx33 status", v, 8'h07);
        waitTicks(1);
        #1 rxd = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = (8'h44 >> i) & 8'h01;
            waitTicks(16);
        end
        #1 rxd = 1'b1;
        waitTicks(8);
        #1 peekStatus(v);
        checkOutput("rx44 before mid stop", v, 8'h07);
        repeat (TICK_DIV - 1) @(posedge clock_in);
        #1 cs = 1'b1; rd = 1'b1; addr = 1'b0;
        #1 oldData = dout;
        @(posedge clock_in);
        #1 cs = 1'b0; rd = 1'b0; addr = 1'b1;
        checkOutput("rx44 read returns old", oldData, 8'h33);
        peekStatus(v);
        checkOutput("rx44 completion wins", v, 8'h0F);
        peekData(v);
        checkOutput("rx44 data", v, 8'h44);
        waitTicks(7);
        #1 cpuRead(v);
        checkOutput("rx44 read", v, 8'h44);

        $display("[TB] RX false start glitch");
        waitTicks(1);
        #1 rxd = 1'b0;
        waitTicks(5);
        #1 rxd = 1'b1;
        waitTicks(170);
        #1 peekStatus(v);
        checkOutput("glitch ignored", v, 8'h06);

        $display("[TB] RX framing error 0x3C");
        sendRxFrame(8'h3C, 1'b0);
        peekStatus(v);
        checkOutput("ferr status", v, 8'h17);
        cpuRead(v);
        checkOutput("ferr data", v, 8'h3C);
        waitTicks(200);
        #1 peekStatus(v);
        checkOutput("ferr waits for high", v, 8'h06);
        rxd = 1'b1;
        waitTicks(20);
        #1 peekStatus(v);
        checkOutput("ferr recovered", v, 8'h06);

        $display("[TB] reset mid-frame");
        waitTicks(1);
        #1 cpuWrite(1'b0, 8'h0F);
        waitTicks(16);
        #1 rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitTicks(16);
            #1 rxd = 1'b1;
        end
        waitTicks(8);
        #1 checkOutput("mid-frame txd bit4", {7'b0, txd}, 8'h00);
        reset = 1'b1;
        @(posedge clock_in);
        #1 checkOutput("reset txd high", {7'b0, txd}, 8'h01);
        peekStatus(v);
        checkOutput("reset status", v, 8'h06);
        peekData(v);
        checkOutput("reset rx data", v, 8'h00);
        @(posedge clock_in);
        #1 reset = 1'b0;

        $display("[TB] 0x7E after reset, TX and RX together");
        waitTicks(1);
        #1 cpuWrite(1'b0, 8'h7E);
        fork
            begin
                waitTicks(1);
                #1;
                checkTxFrame(8'h7E, "tx7E");
            end
            sendRxFrame(8'h7E, 1'b1);
        join
        peekStatus(v);
        checkOutput("7E status", v, 8'h07);
        cpuRead(v);
        checkOutput("rx7E data", v, 8'h7E);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
